// File: rtl/fp_decode_pkg.sv
// fpcvt_pkg: shared fpcvt types and widths for the float encoder and decoder
// Contents: LIN_W/EXP_W/SIG_W widths, fp_code_t {sign, exponent, significand}, fp_decode_state_t
package fpcvt_pkg;
   localparam int LIN_W = 12;
   localparam int EXP_W = 3;
   localparam int SIG_W = 4;
   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exponent;
      logic [SIG_W-1:0] significand;
   } fp_code_t;
   typedef enum logic [1:0] {IDLE, SHIFT, OUT} fp_decode_state_t;
endpackage

// File: rtl/fp_decode_shifter.sv
// fp_decode_shifter: magnitude rebuild, iterative (one bit per cycle) or single-cycle barrel
// Ports: clk, rst (sync, active high); i_load loads i_exp/i_sig;
//        o_mag current magnitude; o_done high once no shifts remain
module fp_decode_shifter #(
   parameter int LIN_W = 12,
   parameter int EXP_W = 3,
   parameter int SIG_W = 4,
   parameter int FAST  = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [EXP_W-1:0] i_exp,
   input  logic [SIG_W-1:0] i_sig,
   output logic [LIN_W-2:0] o_mag,
   output logic             o_done
);
   logic [LIN_W-2:0] r_mag;
   logic [EXP_W-1:0] r_cnt;
   logic [LIN_W-2:0] w_sig;
   assign w_sig  = (LIN_W-1)'(i_sig);
   assign o_mag  = r_mag;
   assign o_done = r_cnt == '0;
   // The FAST build loads the pre-shifted value with no shifts left to do
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mag <= '0;
         r_cnt <= '0;
      end else begin
         r_mag <= i_load ? (FAST != 0 ? w_sig << i_exp : w_sig) : (o_done ? r_mag : r_mag << 1);
         r_cnt <= i_load ? (FAST != 0 ? '0 : i_exp) : (o_done ? r_cnt : r_cnt - 1'b1);
      end
   end
endmodule

// File: rtl/fp_decode.sv
// fp_decode: rebuilds a two's-complement linear sample from an 8-bit float code
// Ports: clk, rst (sync, active high); in_valid/in_ready with in_sign, in_exponent, in_significand;
//        out_valid/out_ready with out_linear and out_noncanon (code was not canonical encoder output)
// Macro FP_DECODE_HALF_LSB_EN: for exponent > 0, reconstruct the midpoint of the quantisation bucket
module fp_decode #(
   parameter int LIN_W = 12,
   parameter int EXP_W = 3,
   parameter int SIG_W = 4,
   parameter int FAST  = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sign,
   input  logic [EXP_W-1:0] in_exponent,
   input  logic [SIG_W-1:0] in_significand,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [LIN_W-1:0] out_linear,
   output logic             out_noncanon
);
   import fpcvt_pkg::*;
   fp_decode_state_t r_state;
   logic             r_sign;
   logic             r_noncanon;
   logic             w_load;
   logic             w_done;
   logic [LIN_W-2:0] w_mag;
   logic [LIN_W-2:0] w_mag_fin;
   logic [LIN_W-1:0] w_lin;
   assign in_ready = r_state == IDLE && !rst;
   assign w_load   = in_valid && in_ready;
   assign w_lin    = {1'b0, w_mag_fin};
   fp_decode_shifter #(.LIN_W(LIN_W), .EXP_W(EXP_W), .SIG_W(SIG_W), .FAST(FAST)) u_shifter (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_load),
      .i_exp  (in_exponent),
      .i_sig  (in_significand),
      .o_mag  (w_mag),
      .o_done (w_done)
   );
`ifdef FP_DECODE_HALF_LSB_EN
   logic [EXP_W-1:0] r_exp;
   always_ff @(posedge clk) begin
      if (rst) r_exp <= '0;
      else if (w_load) r_exp <= in_exponent;
   end
   // Bit e-1 is always zero after the shift, so OR sets the half-step exactly
   assign w_mag_fin = w_mag | (r_exp != '0 ? (LIN_W-1)'(1) << (r_exp - 1'b1) : '0);
`else
   assign w_mag_fin = w_mag;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_sign       <= 1'b0;
         r_noncanon   <= 1'b0;
         out_valid    <= 1'b0;
         out_linear   <= '0;
         out_noncanon <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (in_valid) begin
               r_sign     <= in_sign;
               r_noncanon <= in_exponent != '0 && !in_significand[SIG_W-1];
               r_state    <= SHIFT;
            end
            SHIFT: if (w_done) begin
               out_linear   <= r_sign ? -w_lin : w_lin;
               out_noncanon <= r_noncanon;
               out_valid    <= 1'b1;
               r_state      <= OUT;
            end
            OUT: if (out_ready) begin
               out_valid <= 1'b0;
               r_state   <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule
